ins_mem_ctrl: RTL and testbench

Parametrised, clocked successor to the combinational instruction memory. Byte-addressed instruction store with a valid/ready request port, a programmable number of wait states, a registered 32-bit big-endian instruction response with an error flag, and a byte-wide load port for writing program images at run time. Sits between the multi-cycle CPU's IF stage/PC register and the program image, replacing the `InsMemRW`-gated read.

---
 rtl/ins_mem_pkg.sv | 21 ++
 rtl/ins_mem_array.sv | 32 +++
 rtl/ins_mem_ctrl.sv | 97 +++++++++
 tb/tb_ins_mem_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ins_mem_pkg.sv
// Shared types and constants for the clocked instruction memory controller.
package ins_mem_pkg;

    localparam int ADDR_W = 32;
    localparam int INS_W  = 32;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Extended by one bit so an address near the top of the space cannot wrap into range.
    function automatic logic fetch_err(input logic [ADDR_W-1:0] addr, input int unsigned depth);
        logic [ADDR_W:0] last;
        last = {1'b0, addr} + (ADDR_W+1)'(3);
        return (addr[1:0] != 2'b00) || (last >= (ADDR_W+1)'(depth));
    endfunction

endpackage

// File: rtl/ins_mem_array.sv
// Byte-wide program store: one synchronous byte write, one combinational big-endian word read.
module ins_mem_array
    import ins_mem_pkg::*;
#(
    parameter int    DEPTH_BYTES = 128,
    parameter string INIT_FILE   = "instructions.txt",
    localparam int   AW          = $clog2(DEPTH_BYTES)
) (
    input  logic              clk,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [BYTE_W-1:0] ld_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [INS_W-1:0]  rd_word
);

    logic [BYTE_W-1:0] mem [DEPTH_BYTES];
    logic              ld_hit;

    assign ld_hit = (ld_addr[ADDR_W-1:AW] == '0);

    // No reset on the array so a loaded image survives a controller reset.
    always_ff @(posedge clk) begin
        if (ld_en && ld_hit) mem[ld_addr[AW-1:0]] <= ld_data;
    end

    assign rd_word = {mem[rd_addr],
                      mem[rd_addr + AW'(1)],
                      mem[rd_addr + AW'(2)],
                      mem[rd_addr + AW'(3)]};

endmodule

// File: rtl/ins_mem_ctrl.sv
// Clocked instruction fetch controller: valid/ready request, programmable wait states,
// registered big-endian response with error flag, and a run-time byte load port.
module ins_mem_ctrl
    import ins_mem_pkg::*;
#(
    parameter int    DEPTH_BYTES = 128,
    parameter int    WAIT_CYCLES = 1,
    parameter string INIT_FILE   = "instructions.txt"
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [INS_W-1:0]  rsp_ins,
    output logic              rsp_err,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [BYTE_W-1:0] ld_data
);

    localparam int AW = $clog2(DEPTH_BYTES);

    state_t            state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] rd_addr;
    logic [INS_W-1:0]  rd_word;
    logic              rd_err;

    // With zero wait states the sample happens on the accept edge, before addr_q is loaded.
    assign rd_addr   = (state == IDLE) ? req_addr : addr_q;
    assign rd_err    = fetch_err(rd_addr, DEPTH_BYTES);
    assign req_ready = (state == IDLE);

    ins_mem_array #(
        .DEPTH_BYTES (DEPTH_BYTES),
        .INIT_FILE   (INIT_FILE)
    ) u_array (
        .clk     (CLK),
        .ld_en   (ld_en),
        .ld_addr (ld_addr),
        .ld_data (ld_data),
        .rd_addr (rd_addr[AW-1:0]),
        .rd_word (rd_word)
    );

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            rsp_valid <= 1'b0;
            rsp_ins   <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q <= req_addr;
                        cnt    <= 4'(WAIT_CYCLES);
                        if (WAIT_CYCLES == 0) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= rd_err;
                            rsp_ins   <= rd_err ? '0 : rd_word;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= rd_err;
                        rsp_ins   <= rd_err ? '0 : rd_word;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ins_mem_ctrl.sv
// Scoreboard bench for ins_mem_ctrl: a byte-array reference model predicts every response,
// while two extra instances with zero and fifteen wait states exercise latency and throughput.
module tb_ins_mem_ctrl;

    localparam int DEPTH = 128;

    typedef struct {
        logic [31:0] ins;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_ins;
    logic        rsp_err;
    logic        ld_en;
    logic [31:0] ld_addr;
    logic [7:0]  ld_data;

    logic        aux_valid;
    logic [1:0]  aux_ready;
    logic [1:0]  aux_rvalid;
    logic [1:0]  aux_err;
    logic [31:0] aux_ins0;
    logic [31:0] aux_ins1;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   bp_mode = 0;
    logic mon_en = 1'b0;

    logic [7:0] model [DEPTH];
    exp_t       exp_q [$];
    int         acc_q [$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer side: 0 = always ready, 1 = random back-pressure, 2 = stalled.
    always @(posedge clk) begin
        #1;
        case (bp_mode)
            1:       rsp_ready = ($urandom_range(0, 3) != 0);
            2:       rsp_ready = 1'b0;
            default: rsp_ready = 1'b1;
        endcase
    end

    ins_mem_ctrl #(.DEPTH_BYTES(DEPTH), .WAIT_CYCLES(1), .INIT_FILE("")) dut (
        .CLK(clk), .Reset(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ins(rsp_ins), .rsp_err(rsp_err),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    ins_mem_ctrl #(.DEPTH_BYTES(DEPTH), .WAIT_CYCLES(0), .INIT_FILE("")) dut_w0 (
        .CLK(clk), .Reset(rst),
        .req_valid(aux_valid), .req_ready(aux_ready[0]), .req_addr(32'h0),
        .rsp_valid(aux_rvalid[0]), .rsp_ready(1'b1), .rsp_ins(aux_ins0), .rsp_err(aux_err[0]),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    ins_mem_ctrl #(.DEPTH_BYTES(DEPTH), .WAIT_CYCLES(15), .INIT_FILE("")) dut_w15 (
        .CLK(clk), .Reset(rst),
        .req_valid(aux_valid), .req_ready(aux_ready[1]), .req_addr(32'h0),
        .rsp_valid(aux_rvalid[1]), .rsp_ready(1'b1), .rsp_ins(aux_ins1), .rsp_err(aux_err[1]),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    function automatic logic exp_err(input logic [31:0] a);
        longint unsigned last;
        last = longint'(a) + 3;
        return (a % 4 != 0) || (last >= DEPTH);
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        int i;
        if (exp_err(a)) return 32'h0;
        i = int'(a);
        return {model[i], model[i+1], model[i+2], model[i+3]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic flagTimeout(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s actual=timeout required=handshake (t=%0t)", name, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic loadByte(input logic [31:0] a, input logic [7:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(posedge clk);
        if (a < DEPTH) model[int'(a)] = d;
        #2;
        ld_en = 1'b0;
    endtask

    task automatic issue(input logic [31:0] a);
        exp_t e;
        int   g;
        g = 0;
        while (!req_ready && g < 300) begin
            step();
            g++;
        end
        if (!req_ready) begin
            flagTimeout("req_ready_wait");
            return;
        end
        e.ins = exp_word(a);
        e.err = exp_err(a);
        exp_q.push_back(e);
        req_valid = 1'b1;
        req_addr  = a;
        step();
        req_valid = 1'b0;
        req_addr  = $urandom;
    endtask

    task automatic waitIdle();
        int g;
        g = 0;
        while (!req_ready && g < 300) begin
            step();
            g++;
        end
        if (!req_ready) flagTimeout("return_to_idle");
    endtask

    task automatic applyStimulus(input logic [31:0] a);
        issue(a);
        waitIdle();
    endtask

    // Scoreboard monitor for the main instance.
    logic        prev_v = 1'b0;
    logic        prev_r = 1'b0;
    logic [31:0] prev_ins = '0;
    logic        prev_err = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (rsp_valid) checkOutput("valid_ready_exclusive", {31'b0, req_ready}, 32'h0);
            if (req_valid && req_ready) acc_q.push_back(cyc + 1);
            if (rsp_valid && !prev_v) begin
                if (acc_q.size() == 0) begin
                    flagTimeout("unexpected_response");
                end else begin
                    checkOutput("latency", cyc - acc_q.pop_front() + 1, 32'd2);
                end
            end
            if (rsp_valid && prev_v && !prev_r) begin
                checkOutput("stall_ins_stable", rsp_ins, prev_ins);
                checkOutput("stall_err_stable", {31'b0, rsp_err}, {31'b0, prev_err});
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    flagTimeout("unexpected_handshake");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkOutput("rsp_ins", rsp_ins, e.ins);
                    checkOutput("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
                end
            end
        end
        prev_v   = rsp_valid;
        prev_r   = rsp_ready;
        prev_ins = rsp_ins;
        prev_err = rsp_err;
    end

    // Latency and accept spacing for the zero and fifteen wait-state instances.
    int         aux_w [2] = '{0, 15};
    int         last_acc [2] = '{-1, -1};
    logic [1:0] aux_prev = 2'b00;

    always @(negedge clk) begin
        if (mon_en) begin
            for (int j = 0; j < 2; j++) begin
                if (aux_valid && aux_ready[j]) begin
                    if (last_acc[j] >= 0)
                        checkOutput($sformatf("aux_w%0d_period", aux_w[j]), cyc + 1 - last_acc[j], aux_w[j] + 2);
                    last_acc[j] = cyc + 1;
                end
                if (aux_rvalid[j] && !aux_prev[j] && last_acc[j] >= 0) begin
                    checkOutput($sformatf("aux_w%0d_latency", aux_w[j]), cyc - last_acc[j] + 1, aux_w[j] + 1);
                    checkOutput($sformatf("aux_w%0d_ins", aux_w[j]), (j == 0) ? aux_ins0 : aux_ins1, exp_word(32'h0));
                    checkOutput($sformatf("aux_w%0d_err", aux_w[j]), {31'b0, aux_err[j]}, 32'h0);
                end
                aux_prev[j] = aux_rvalid[j];
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic [7:0]  img [8];
        int          g;
        img = '{8'h02, 8'h00, 8'h00, 8'h01, 8'h03, 8'h00, 8'h00, 8'h02};

        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        ld_en     = 1'b0;
        ld_addr   = '0;
        ld_data   = '0;
        aux_valid = 1'b0;
        repeat (3) step();
        checkOutput("reset_req_ready", {31'b0, req_ready}, 32'h1);
        checkOutput("reset_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        checkOutput("reset_rsp_ins", rsp_ins, 32'h0);
        checkOutput("reset_rsp_err", {31'b0, rsp_err}, 32'h0);
        rst = 1'b0;
        step();
        mon_en = 1'b1;

        for (int i = 0; i < DEPTH; i++) loadByte(i, 8'($urandom));
        for (int i = 0; i < 8; i++) loadByte(i, img[i]);

        aux_valid = 1'b1;
        repeat (80) step();
        aux_valid = 1'b0;
        repeat (20) step();

        applyStimulus(32'h4);
        applyStimulus(32'h6);
        applyStimulus(32'h7C);
        applyStimulus(32'h80);

        loadByte(32'h10, 8'hDE);
        loadByte(32'h11, 8'hAD);
        loadByte(32'h12, 8'hBE);
        loadByte(32'h13, 8'hEF);
        applyStimulus(32'h10);
        loadByte(32'h90, 8'h77);
        applyStimulus(32'h10);

        // Write lands on the same edge that samples the word: old byte expected.
        issue(32'h10);
        loadByte(32'h11, 8'h5A);
        waitIdle();
        applyStimulus(32'h10);

        bp_mode = 2;
        step();
        issue(32'h4);
        step();
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall_rsp_valid", {31'b0, rsp_valid}, 32'h1);
            checkOutput("stall_req_ready", {31'b0, req_ready}, 32'h0);
            step();
        end
        bp_mode = 0;
        step();
        checkOutput("release_rsp_valid", {31'b0, rsp_valid}, 32'h1);
        step();
        checkOutput("after_hs_req_ready", {31'b0, req_ready}, 32'h1);
        checkOutput("after_hs_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        checkOutput("after_hs_ins_hold", rsp_ins, exp_word(32'h4));

        issue(32'h8);
        rst = 1'b1;
        #1;
        checkOutput("abort_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        checkOutput("abort_req_ready", {31'b0, req_ready}, 32'h1);
        exp_q.delete();
        acc_q.delete();
        #1;
        step();
        rst = 1'b0;
        repeat (4) step();
        applyStimulus(32'h4);
        applyStimulus(32'h10);

        bp_mode = 1;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 2) == 0) loadByte($urandom_range(0, 255), 8'($urandom));
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: a = $urandom_range(0, 31) * 4;
                5:             a = $urandom_range(0, 31) * 4 + $urandom_range(1, 3);
                6:             a = $urandom_range(125, 255);
                7:             a = $urandom;
                8:             a = 32'hFFFF_FFFC;
                default:       a = 32'h7C;
            endcase
            applyStimulus(a);
        end
        bp_mode = 0;

        g = 0;
        while (exp_q.size() != 0 && g < 300) begin
            step();
            g++;
        end
        if (exp_q.size() != 0) flagTimeout("drain");
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
